// File: rtl/stream_fork_pkg.sv
// Shared helpers for stream_fork: log2 and derived pointer/count widths.
// Widths are functions of the depth because the depth is a module parameter.
package stream_fork_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   // Depth 1 still needs a one-bit pointer so the storage index is legal.
   function automatic int unsigned ptr_w(input int unsigned d);
      return (clog2(d) == 0) ? 1 : clog2(d);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned d);
      return clog2(d) + 1;
   endfunction

endpackage

// File: rtl/stream_fork_fifo.sv
// Single-channel W x D FIFO for stream_fork. With STREAM_FORK_BYPASS_EN defined,
// an empty FIFO passes the incoming beat straight to its master port.
module stream_fork_fifo
   import stream_fork_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned D = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   output logic         full,
   input  logic         m_rdy,
   output logic         m_stb,
   output logic [W-1:0] m_dat
);

   localparam int unsigned PW = ptr_w(D);
   localparam int unsigned CW = cnt_w(D);

   if (!is_pow2(D)) begin : g_depth_chk
      $error("stream_fork_fifo: D must be a power of two");
   end

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  mem_q [D];
   logic          empty, wr, rd;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(D));

   always_comb begin
      m_stb = ~empty;
      m_dat = mem_q[rd_ptr_q];
      wr    = push;
      rd    = ~empty & m_rdy;
`ifdef STREAM_FORK_BYPASS_EN
      // A beat consumed in the cycle it arrives never touches storage.
      if (empty) begin
         m_stb = push;
         m_dat = push_dat;
         wr    = push & ~m_rdy;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(D); i++) mem_q[i] <= '0;
      end else begin
         if (wr) begin
            mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (rd) begin
            rd_ptr_q <= (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/stream_fork.sv
// Fans one slave stream out to N buffered master channels under a destination mask.
// Optional zero-latency bypass on empty channels: define STREAM_FORK_BYPASS_EN.
module stream_fork
   import stream_fork_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned N = 2,
   parameter int unsigned D = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_stb,
   input  logic [N-1:0]   s_msk,
   input  logic [N*W-1:0] s_dat,
   output logic           s_rdy,
   input  logic [N-1:0]   m_rdy,
   output logic [N-1:0]   m_stb,
   output logic [N*W-1:0] m_dat
);

   logic [N-1:0] full;
   logic [N-1:0] push;

   // All-or-nothing: every selected channel must have room; m_rdy is never consulted.
   assign s_rdy = &(~s_msk | ~full);
   assign push  = {N{s_stb & s_rdy}} & s_msk;

   for (genvar g = 0; g < N; g++) begin : g_chan
      stream_fork_fifo #(
         .W (W),
         .D (D)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[g]),
         .push_dat (s_dat[g*W +: W]),
         .full     (full[g]),
         .m_rdy    (m_rdy[g]),
         .m_stb    (m_stb[g]),
         .m_dat    (m_dat[g*W +: W])
      );
   end

endmodule

// File: doc/stream_fork.md
Name: stream_fork

Overview:
- Parametrised successor to the lock-step stream splitter: one slave stream fans out to N master channels.
- Each channel has its own FIFO of depth D, so a slow consumer no longer stalls the others beyond its buffer depth.
- A per-transfer destination mask adds multicast and unicast routing, which the lock-step splitter lacks.
- Sits between a producer and N independent consumers in the datapath fabric, using the standard stb/rdy/dat handshake.

Parameters:
- W, 8, data width per channel (≥1).
- N, 2, number of master channels (≥1).
- D, 2, FIFO depth per channel in entries (power of two, ≥1).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_stb  input  1  slave strobe; a transfer occurs when s_stb & s_rdy.
- s_msk  input  N  destination mask; bit i routes the transfer to channel i. Valid when s_stb is high.
- s_dat  input  N*W  slave data; slice i (bits i*W+W-1 : i*W) goes to channel i.
- s_rdy  output  1  slave ready.
- m_rdy  input  N  per-channel master ready.
- m_stb  output  N  per-channel master strobe.
- m_dat  output  N*W  per-channel master data, slice i belongs to channel i.

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs empty, pointers and counts zero, storage cleared. m_stb=0, m_dat=0, s_rdy=1. Deassertion is synchronous to clk. Reset mid-operation discards all buffered data, with no partial delivery afterwards.
- Each channel i holds occupancy cnt[i] in 0..D (width clog2(D)+1). full[i] = (cnt[i]==D); empty[i] = (cnt[i]==0).
- s_rdy = AND over i of (~s_msk[i] | ~full[i]).
  - Combinational in s_msk and full only; never depends on s_stb or m_rdy.
  - All-or-nothing: a transfer is accepted only when every selected channel has space.
- Zero mask: s_rdy=1. The transfer is consumed and dropped; no FIFO changes.
- Write to channel i: wr[i] = s_stb & s_rdy & s_msk[i]. Slice i is stored at the tail and cnt[i] increments.
- Read from channel i: m_stb[i] = ~empty[i]; m_dat slice i = head entry. rd[i] = m_stb[i] & m_rdy[i] pops the head and cnt[i] decrements.
- Simultaneous wr[i] & rd[i]: cnt[i] unchanged, head advances, new entry appended. This is legal at any occupancy below D. At full, wr[i] cannot occur, so there is no write-through on a full FIFO.
- Pointers wrap modulo D. D=1 degenerates to a single register per channel.
- Latency: a transfer accepted in cycle k appears on m_stb[i] in cycle k+1 at the earliest.
- Ordering: per-channel FIFO order is preserved. There is no ordering relation across channels.
- m_stb[i] and m_dat slice i are stable while m_stb[i]=1 & m_rdy[i]=0.
- Throughput: one transfer per cycle when all selected channels keep m_rdy high.

Optional Feature:
- Macro: STREAM_FORK_BYPASS_EN.
- Defined: when empty[i], the channel is combinationally transparent.
  - m_stb[i] = s_stb & s_msk[i] & s_rdy.
  - m_dat slice i = s_dat slice i.
  - If m_rdy[i] is also high, the beat is delivered in the same cycle (zero latency) and is not stored: wr[i] is suppressed and cnt[i] stays 0.
  - If m_rdy[i] is low, the beat is stored as normal.
  - Adds a combinational path s_stb/s_msk/s_dat → m_stb/m_dat. No loop, because s_rdy ignores m_rdy.
- Undefined: no combinational path from slave to master outputs; minimum latency 1 cycle.

Decomposition:
- Package stream_fork_pkg holds:
  - a clog2 function;
  - the derived pointer width PW=clog2(D) and count width CW=PW+1;
  - an elaboration check that D is a power of two.
- One natural sub-module: stream_fork_fifo, a single-channel W×D FIFO with wr/rd/full/empty/head. It is instantiated N times in a generate loop, and the bypass mux lives inside it.
- The top level holds only the s_rdy reduction and the wr[i] fan-out.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release → s_rdy=1, m_stb=00, m_dat=0; an async assertion mid-cycle clears m_stb without a clock edge.
- Broadcast, N=2 D=2: s_msk=11, s_dat=0xB2A1, m_rdy=11 → cycle k+1 m_stb=11, m_dat=0xB2A1; a 4-beat burst sustains 1 beat/cycle.
- Independent stall: m_rdy=01, broadcast 3 beats 0x11,0x22,0x33 → channel 0 drains all 3; channel 1 fills to 2 and s_rdy drops on the 3rd beat. Raise m_rdy[1] → the 3rd beat is accepted and channel 1 emits 0x11,0x22,0x33 in order.
- Unicast past a full channel: channel 1 full, s_msk=01 → s_rdy=1 and the beat goes to channel 0 only; s_msk=10 → s_rdy=0.
- Zero mask: s_msk=00, s_stb=1 → s_rdy=1, the beat is dropped, all cnt unchanged, m_stb stays 00.
- STREAM_FORK_BYPASS_EN: FIFOs empty, m_rdy=11, s_msk=11, s_dat=0x5A5A → m_stb=11 and m_dat=0x5A5A in the same cycle, FIFOs stay empty. Same stimulus without the macro → delivered at k+1.
